// File: rtl/dpram_tap_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpram_tap_reader: delayed-tap read controller for the dual-port sample    |
// | RAM, with muted warm-up and a 4-deep valid/ready output FIFO. Rev 1.0     |
// +--------------------------------------------------------------------------+
module dpram_tap_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_strobe,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  delay_load,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [3:0]            PEND_FULL = 4'hF;
  localparam logic [2:0]            FIFO_DEPTH = 3'd4;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0]   dly;
  logic [ADDR_WIDTH-1:0]   fill;
  logic [3:0]              pend;
  logic                    mute_rd;
  logic                    cap_pending;
  logic                    mute_cap;
  logic [DATA_WIDTH-1:0]   fifo_mem [4];
  logic [1:0]              head;
  logic [1:0]              tail;
  logic [2:0]              fifo_count;
  logic [2:0]              occupancy;
  logic                    issue;
  logic                    strobe_in;
  logic                    push;
  logic                    pop;

  // FIFO entries plus reads still travelling through the RAM bound the issue rate
  assign occupancy = fifo_count + {2'b00, rden} + {2'b00, cap_pending};
  assign issue     = !delay_load && (pend != 4'd0) && (occupancy < FIFO_DEPTH);
  assign strobe_in = wr_strobe && !delay_load;
  assign push      = cap_pending && !delay_load;
  assign m_valid   = (fifo_count != 3'd0);
  assign pop       = m_valid && m_ready && !delay_load;
  assign m_data    = fifo_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (delay == '0) ? RUN : WARM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (delay_load) begin
      state_nxt = (delay == '0) ? RUN : WARM;
    end else if ((state == WARM) && issue && (fill == (dly - ADDR_ONE))) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || delay_load) begin
      rd_ptr      <= wr_addr - delay;
      dly         <= delay;
      fill        <= '0;
      pend        <= 4'd0;
      rden        <= 1'b0;
      cap_pending <= 1'b0;
      mute_rd     <= 1'b0;
      mute_cap    <= 1'b0;
      if (rst) begin
        rdaddress <= '0;
      end
    end else begin
      rden        <= issue;
      cap_pending <= rden;
      mute_cap    <= mute_rd;
      if (issue) begin
        rdaddress <= rd_ptr;
        rd_ptr    <= rd_ptr + ADDR_ONE;
        mute_rd   <= (state == WARM);
        if (state == WARM) begin
          fill <= fill + ADDR_ONE;
        end
      end
      if (strobe_in && !issue) begin
        if (pend != PEND_FULL) begin
          pend <= pend + 4'd1;
        end
      end else if (!strobe_in && issue) begin
        pend <= pend - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (strobe_in && !issue && (pend == PEND_FULL)) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      fifo_count <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (delay_load) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[tail] <= mute_cap ? '0 : q;
        tail           <= tail + 2'd1;
      end
      if (pop) begin
        head <= head + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_tap_reader.sv
`default_nettype none
// Bench for dpram_tap_reader: behavioural RAM, directed steps, scoreboard queues
// for the output stream and the read-address sequence.
module tb_dpram_tap_reader;

  logic        clk;
  logic        rst;
  logic [10:0] wr_addr;
  logic        wr_strobe;
  logic [15:0] wr_data;
  logic [10:0] delay;
  logic        delay_load;
  logic        rden;
  logic [10:0] rdaddress;
  logic [15:0] q;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        overrun;

  logic [15:0] ram [0:2047];
  logic [15:0] out_q [$];
  logic [10:0] addr_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t_strobe = 0;
  int          t_valid = 0;
  bit          seen_valid = 0;
  bit          chk_addr = 0;

  dpram_tap_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_strobe(wr_strobe),
    .delay(delay), .delay_load(delay_load), .rden(rden), .rdaddress(rdaddress),
    .q(q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-before-write RAM: q is the old word when read and write collide
  always @(posedge clk) begin
    if (rden) q <= ram[rdaddress];
    if (wr_strobe) ram[wr_addr] = wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [10:0] a, input logic [10:0] d);
    rst = 1'b1; wr_addr = a; delay = d; wr_strobe = 1'b0; delay_load = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((out_q.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check(tag, out_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        t_valid = cyc;
      end
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) check("out_extra", 0, 1);
        else check("out_data", m_data, out_q.pop_front());
      end
      if (chk_addr && rden) begin
        if (addr_q.size() == 0) check("rdaddr_extra", 0, 1);
        else check("rdaddress", rdaddress, addr_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 16'(a + 100);
    wr_data = '0; m_ready = 1'b1;

    // Reset values, then delay=3 stream over addresses 0..7
    do_reset(11'd0, 11'd3);
    check("rst_rden", rden, 0);
    check("rst_rdaddress", rdaddress, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overrun", overrun, 0);
    for (int k = 0; k < 3; k++) out_q.push_back(16'd0);
    for (int k = 0; k < 5; k++) out_q.push_back(16'(100 + k));
    addr_q.push_back(11'd2045); addr_q.push_back(11'd2046); addr_q.push_back(11'd2047);
    for (int k = 0; k < 5; k++) addr_q.push_back(11'(k));
    chk_addr = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_addr = 11'(i); wr_data = 16'(i + 100); wr_strobe = 1'b1;
      if (i == 0) t_strobe = cyc + 1;
      tick();
    end
    wr_strobe = 1'b0;
    drain("t1_drain", 40);
    check("t1_addr_left", addr_q.size(), 0);
    check("t1_latency", t_valid - t_strobe, 3);
    chk_addr = 1'b0;

    // delay=0: new data returned, no muted sample
    do_reset(11'd17, 11'd0);
    out_q.push_back(16'h1234);
    seen_valid = 1'b0;
    wr_addr = 11'd17; wr_data = 16'h1234; wr_strobe = 1'b1;
    t_strobe = cyc + 1;
    tick();
    wr_strobe = 1'b0;
    drain("t2_drain", 20);
    check("t2_latency", t_valid - t_strobe, 3);

    // Read pointer wraps 2047 -> 0
    do_reset(11'd0, 11'd1);
    chk_addr = 1'b1;
    addr_q.push_back(11'd2047); addr_q.push_back(11'd0);
    out_q.push_back(16'd0); out_q.push_back(16'h5A5A);
    wr_addr = 11'd0; wr_data = 16'h5A5A; wr_strobe = 1'b1; tick();
    wr_addr = 11'd1; wr_data = 16'h1111; tick();
    wr_strobe = 1'b0;
    drain("t3_drain", 20);
    check("t3_addr_left", addr_q.size(), 0);
    chk_addr = 1'b0;

    // Back-pressure: 30 strobes with m_ready low, 20th strobe overruns
    m_ready = 1'b0;
    do_reset(11'd0, 11'd0);
    for (int k = 0; k < 19; k++) out_q.push_back(16'(100 + k));
    for (int i = 0; i < 30; i++) begin
      wr_addr = 11'(i); wr_data = 16'(i + 100); wr_strobe = 1'b1;
      tick();
      if (i == 18) check("t4_ovr_19th", overrun, 0);
      if (i == 19) check("t4_ovr_20th", overrun, 1);
      if ((i == 10) || (i == 29)) begin
        check("t4_stall_valid", m_valid, 1);
        check("t4_stall_data", m_data, 16'd100);
      end
    end
    wr_strobe = 1'b0;
    m_ready = 1'b1;
    drain("t4_drain", 60);
    check("t4_ovr_sticky", overrun, 1);

    // delay_load with a capture in flight, 2 FIFO entries and a coincident strobe
    m_ready = 1'b0;
    do_reset(11'd0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      wr_addr = 11'(i); wr_data = 16'(i + 100); wr_strobe = 1'b1;
      tick();
    end
    wr_strobe = 1'b0;
    repeat (2) tick();
    check("t5_pre_valid", m_valid, 1);
    delay_load = 1'b1; delay = 11'd2; wr_addr = 11'd3; wr_data = 16'h7777; wr_strobe = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    delay_load = 1'b0; wr_strobe = 1'b0;
    @(negedge clk);
    check("t5_flush_valid", m_valid, 0);
    m_ready = 1'b1;
    out_q.push_back(16'd0); out_q.push_back(16'd0);
    out_q.push_back(16'h7777); out_q.push_back(16'd204);
    tick();
    for (int i = 4; i < 8; i++) begin
      wr_addr = 11'(i); wr_data = 16'(i + 200); wr_strobe = 1'b1;
      tick();
    end
    wr_strobe = 1'b0;
    drain("t5_drain", 40);

    // Strobe and issue on the same edge hold pend at 5
    m_ready = 1'b0;
    do_reset(11'd0, 11'd0);
    for (int k = 0; k < 10; k++) out_q.push_back(16'(100 + k));
    for (int i = 0; i < 9; i++) begin
      wr_addr = 11'(i); wr_data = 16'(i + 100); wr_strobe = 1'b1;
      tick();
    end
    wr_strobe = 1'b0;
    repeat (2) tick();
    check("t6_pend_before", dut.pend, 5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    wr_addr = 11'd9; wr_data = 16'd109; wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    check("t6_issue", rden, 1);
    check("t6_pend_hold", dut.pend, 5);
    m_ready = 1'b1;
    drain("t6_drain", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
